// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps a single instruction-memory
// request in flight, and hands instruction/PC pairs to decode over a
// valid/ready handshake. A redirect from the branch stage reloads the PC
// and kills whatever fetch is outstanding or held.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] new_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_misaligned
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  // Set when the request in flight belongs to a killed path; its rvalid
  // must be swallowed rather than delivered.
  logic        discard_q, discard_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        if_mis_q, if_mis_d;

  // Memory sees a word-aligned address; the low PC bits only feed the
  // misalignment flag.
  assign imem_req      = (state_q == REQ);
  assign imem_addr     = {pc_q[31:2], 2'b00};
  assign if_valid      = (state_q == HOLD);
  assign if_pc         = if_pc_q;
  assign if_instr      = if_instr_q;
  assign if_misaligned = if_mis_q;

  // Next-state and datapath updates; redirect always wins over progress.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    discard_d  = discard_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    if_mis_d   = if_mis_q;
    case (state_q)
      IDLE: begin
        state_d = REQ;
        if (redirect) pc_d = new_pc;
      end
      REQ: begin
        if (imem_gnt) begin
          state_d   = WAIT;
          // A grant coinciding with a redirect fetched the old PC.
          discard_d = redirect;
        end
        if (redirect) pc_d = new_pc;
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (discard_q || redirect) begin
            state_d   = REQ;
            discard_d = 1'b0;
            if (redirect) pc_d = new_pc;
          end else begin
            state_d    = HOLD;
            if_instr_d = imem_rdata;
            if_pc_d    = pc_q;
            if_mis_d   = (pc_q[1:0] != 2'b00);
          end
        end else if (redirect) begin
          // Still owe the memory one rvalid; remember to drop it.
          pc_d      = new_pc;
          discard_d = 1'b1;
        end
      end
      HOLD: begin
        if (redirect) begin
          state_d    = REQ;
          pc_d       = new_pc;
          if_instr_d = NOP_INSTR;
          if_mis_d   = 1'b0;
        end else if (if_ready) begin
          state_d    = REQ;
          pc_d       = pc_q + 32'd4;
          if_instr_d = NOP_INSTR;
          if_mis_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      discard_q  <= 1'b0;
      if_pc_q    <= RESET_PC;
      if_instr_q <= NOP_INSTR;
      if_mis_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      discard_q  <= discard_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      if_mis_q   <= if_mis_d;
    end
  end

endmodule
